// File: rtl/instruction_fetch.sv
// MIPS front stage: PC register, debug-loaded instruction memory, IF/ID latch,
// redirects, stalls, flushes and HALT detection. Optional FETCH_COUNT_EN adds a fetched-word counter.
module instruction_fetch #(
  parameter int              NB         = 32,
  parameter int              IMEM_WORDS = 256,
  parameter int              ADDR_NB    = 8,
  parameter logic [NB-1:0]   HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic               i_start,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_branch_taken,
  input  logic [NB-1:0]      i_branch_addr,
  input  logic               i_jump,
  input  logic [NB-1:0]      i_jump_addr,
  input  logic               i_load_en,
  input  logic [ADDR_NB-1:0] i_load_addr,
  input  logic [NB-1:0]      i_load_data,
  output logic [NB-1:0]      o_instruction,
  output logic [NB-1:0]      o_pc4,
  output logic [NB-1:0]      o_pc,
  output logic               o_halted,
  output logic [NB-1:0]      o_fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  localparam logic [NB-1:0] NOP     = '0;
  localparam logic [NB-1:0] PC_STEP = NB'(4);

  state_t        state, state_next;
  logic [NB-1:0] pc, pc_next;
  logic [NB-1:0] instr, instr_next;
  logic [NB-1:0] pc4, pc4_next;
  logic [NB-1:0] imem [IMEM_WORDS];
  logic [NB-1:0] fetched, pc_plus4;
  logic          redirect, latch_word, is_halt;

  // Word-addressed read; PC[1:0] and bits above the memory depth are ignored.
  assign fetched  = imem[pc[ADDR_NB+1:2]];
  assign pc_plus4 = pc + PC_STEP;
  assign redirect = i_branch_taken | i_jump;
  assign is_halt  = (fetched == HALT_WORD);

  // NOTE: program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge i_clk) begin
    if (i_reset && state == IDLE && i_load_en)
      imem[i_load_addr] <= i_load_data;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    pc4_next   = pc4;
    latch_word = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_next = RUN;
      end
      RUN: begin
        if (i_step) begin
          latch_word = !(i_flush | redirect | i_stall);
          if (i_branch_taken)                 pc_next = i_branch_addr;
          else if (i_jump)                    pc_next = i_jump_addr;
          else if (i_stall)                   pc_next = pc;
          else if (latch_word && is_halt)     pc_next = pc;
          else                                pc_next = pc_plus4;

          if (i_flush || redirect) begin
            instr_next = NOP;
            pc4_next   = '0;
          end else if (latch_word) begin
            instr_next = fetched;
            pc4_next   = pc_plus4;
            if (is_halt) state_next = HALTED;
          end
        end
      end
      HALTED: begin
        if (i_step) begin
          instr_next = NOP;
          pc4_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= IDLE;
      pc    <= '0;
      instr <= NOP;
      pc4   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
      pc4   <= pc4_next;
    end
  end

  assign o_instruction = instr;
  assign o_pc4         = pc4;
  assign o_pc          = pc;
  assign o_halted      = (state == HALTED);

`ifdef FETCH_COUNT_EN
  logic [NB-1:0] fetch_count;

  // Counts only words that actually enter IF/ID from memory, HALT included.
  always_ff @(posedge i_clk) begin
    if (!i_reset)        fetch_count <= '0;
    else if (latch_word) fetch_count <= fetch_count + NB'(1);
  end

  assign o_fetch_count = fetch_count;
`else
  assign o_fetch_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected IF/ID, PC, halt and count values are queued
// as each step is driven and compared after the advancing edge.
module tb_instruction_fetch;

  localparam logic [31:0] W0   = 32'h20010005;
  localparam logic [31:0] W1   = 32'h20020003;
  localparam logic [31:0] W2   = 32'h00221820;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [31:0] W8   = 32'h8C0A0010;
  localparam logic [31:0] W16  = 32'h3C0B1234;
  localparam logic [31:0] WNEW = 32'h24030007;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_step = 1'b0, i_start = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic        i_branch_taken = 1'b0, i_jump = 1'b0, i_load_en = 1'b0;
  logic [31:0] i_branch_addr = '0, i_jump_addr = '0, i_load_data = '0;
  logic [7:0]  i_load_addr = '0;
  logic [31:0] o_instruction, o_pc4, o_pc, o_fetch_count;
  logic        o_halted;

  instruction_fetch dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_start(i_start),
    .i_stall(i_stall), .i_flush(i_flush),
    .i_branch_taken(i_branch_taken), .i_branch_addr(i_branch_addr),
    .i_jump(i_jump), .i_jump_addr(i_jump_addr),
    .i_load_en(i_load_en), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
    .o_instruction(o_instruction), .o_pc4(o_pc4), .o_pc(o_pc),
    .o_halted(o_halted), .o_fetch_count(o_fetch_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] cnt(input int n);
`ifdef FETCH_COUNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic step, input logic stall, input logic flush,
                       input logic br, input logic [31:0] baddr,
                       input logic jmp, input logic [31:0] jaddr);
    i_step = step; i_stall = stall; i_flush = flush;
    i_branch_taken = br; i_branch_addr = baddr;
    i_jump = jmp; i_jump_addr = jaddr;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    i_start = 0; i_load_en = 0;
    i_reset = 0;
    tick();
    i_reset = 1;
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    i_load_en = 1; i_load_addr = addr; i_load_data = data;
    tick();
    i_load_en = 0;
  endtask

  task automatic start();
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1, 1, 1, 1, 32'h40, 1, 32'h20);
    i_start = 1;
    i_reset = 0;
    exp_q.push_back('{32'h0, 32'h0, 32'h0, 1'b0, 32'h0});
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (o_instruction !== e.instr || o_pc4 !== e.pc4 || o_pc !== e.pc ||
        o_halted !== e.halted || o_fetch_count !== e.cnt)
      $display("FAIL reset: got instr=%h pc4=%h pc=%h halted=%b cnt=%0d want instr=%h pc4=%h pc=%h halted=%b cnt=%0d",
               o_instruction, o_pc4, o_pc, o_halted, o_fetch_count, e.instr, e.pc4, e.pc, e.halted, e.cnt);
    else n_pass++;
    i_start = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    i_reset = 1;
  endtask

  task automatic test_basic();
    exp_t e;
    exp_t t [7] = '{
      '{32'h0, 32'h0,  32'h0,  1'b0, cnt(0)},
      '{32'h0, 32'h0,  32'h0,  1'b0, cnt(0)},
      '{W0,    32'd4,  32'd4,  1'b0, cnt(1)},
      '{W1,    32'd8,  32'd8,  1'b0, cnt(2)},
      '{W2,    32'd12, 32'd12, 1'b0, cnt(3)},
      '{HALT,  32'd16, 32'd12, 1'b1, cnt(4)},
      '{32'h0, 32'h0,  32'd12, 1'b1, cnt(4)}
    };
    load(8'd0, W0); load(8'd1, W1); load(8'd2, W2); load(8'd8, W8); load(8'd16, W16);
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(t[k]);
      if (k == 0)      load(8'd3, HALT);
      else if (k == 1) start();
      else begin
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
      end
      e = exp_q.pop_front();
      n_checks++;
      if (o_instruction !== e.instr || o_pc4 !== e.pc4 || o_pc !== e.pc ||
          o_halted !== e.halted || o_fetch_count !== e.cnt)
        $display("FAIL basic[%0d]: got instr=%h pc4=%h pc=%h halted=%b cnt=%0d want instr=%h pc4=%h pc=%h halted=%b cnt=%0d",
                 k, o_instruction, o_pc4, o_pc, o_halted, o_fetch_count, e.instr, e.pc4, e.pc, e.halted, e.cnt);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    exp_t e;
    logic stall_seq [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_t t [5] = '{
      '{W0, 32'd4,  32'd4,  1'b0, cnt(1)},
      '{W0, 32'd4,  32'd4,  1'b0, cnt(1)},
      '{W0, 32'd4,  32'd4,  1'b0, cnt(1)},
      '{W1, 32'd8,  32'd8,  1'b0, cnt(2)},
      '{W2, 32'd12, 32'd12, 1'b0, cnt(3)}
    };
    apply_reset();
    start();
    for (int k = 0; k < 5; k++) begin
      drive(1, stall_seq[k], 0, 0, 0, 0, 0);
      exp_q.push_back(t[k]);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (o_instruction !== e.instr || o_pc4 !== e.pc4 || o_pc !== e.pc ||
          o_halted !== e.halted || o_fetch_count !== e.cnt)
        $display("FAIL stall[%0d]: got instr=%h pc4=%h pc=%h halted=%b cnt=%0d want instr=%h pc4=%h pc=%h halted=%b cnt=%0d",
                 k, o_instruction, o_pc4, o_pc, o_halted, o_fetch_count, e.instr, e.pc4, e.pc, e.halted, e.cnt);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jump();
    exp_t e;
    logic jmp_seq [3] = '{1'b0, 1'b1, 1'b0};
    exp_t t [3] = '{
      '{W0,    32'd4,  32'd4,  1'b0, cnt(1)},
      '{32'h0, 32'h0,  32'h20, 1'b0, cnt(1)},
      '{W8,    32'h24, 32'h24, 1'b0, cnt(2)}
    };
    apply_reset();
    start();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, jmp_seq[k], 32'h20);
      exp_q.push_back(t[k]);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (o_instruction !== e.instr || o_pc4 !== e.pc4 || o_pc !== e.pc ||
          o_halted !== e.halted || o_fetch_count !== e.cnt)
        $display("FAIL jump[%0d]: got instr=%h pc4=%h pc=%h halted=%b cnt=%0d want instr=%h pc4=%h pc=%h halted=%b cnt=%0d",
                 k, o_instruction, o_pc4, o_pc, o_halted, o_fetch_count, e.instr, e.pc4, e.pc, e.halted, e.cnt);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Branch beats jump, flush beats stall, and no step means nothing moves.
  task automatic test_branch_priority();
    exp_t e;
    logic step_seq  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic stall_seq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic flush_seq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic br_seq    [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic jmp_seq   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_t t [5] = '{
      '{W0,    32'd4,  32'd4,  1'b0, cnt(1)},
      '{32'h0, 32'h0,  32'h40, 1'b0, cnt(1)},
      '{W16,   32'h44, 32'h44, 1'b0, cnt(2)},
      '{32'h0, 32'h0,  32'h44, 1'b0, cnt(2)},
      '{32'h0, 32'h0,  32'h44, 1'b0, cnt(2)}
    };
    apply_reset();
    start();
    for (int k = 0; k < 5; k++) begin
      drive(step_seq[k], stall_seq[k], flush_seq[k], br_seq[k], 32'h40, jmp_seq[k], 32'h20);
      exp_q.push_back(t[k]);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (o_instruction !== e.instr || o_pc4 !== e.pc4 || o_pc !== e.pc ||
          o_halted !== e.halted || o_fetch_count !== e.cnt)
        $display("FAIL branch_prio[%0d]: got instr=%h pc4=%h pc=%h halted=%b cnt=%0d want instr=%h pc4=%h pc=%h halted=%b cnt=%0d",
                 k, o_instruction, o_pc4, o_pc, o_halted, o_fetch_count, e.instr, e.pc4, e.pc, e.halted, e.cnt);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Load ignored in RUN, reset mid-run, then stepping without start stays in IDLE.
  task automatic test_load_in_run();
    exp_t e;
    exp_t t [4] = '{
      '{32'h0, 32'h0, 32'h0, 1'b0, cnt(0)},
      '{W0,    32'd4, 32'd4, 1'b0, cnt(1)},
      '{32'h0, 32'h0, 32'h0, 1'b0, 32'h0},
      '{32'h0, 32'h0, 32'h0, 1'b0, 32'h0}
    };
    apply_reset();
    start();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(t[k]);
      if (k == 0) load(8'd0, 32'hDEADBEEF);
      else begin
        drive(1, 0, 0, 0, 0, 0, 0);
        if (k == 2) i_reset = 0;
        tick();
        i_reset = 1;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (o_instruction !== e.instr || o_pc4 !== e.pc4 || o_pc !== e.pc ||
          o_halted !== e.halted || o_fetch_count !== e.cnt)
        $display("FAIL load_in_run[%0d]: got instr=%h pc4=%h pc=%h halted=%b cnt=%0d want instr=%h pc4=%h pc=%h halted=%b cnt=%0d",
                 k, o_instruction, o_pc4, o_pc, o_halted, o_fetch_count, e.instr, e.pc4, e.pc, e.halted, e.cnt);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Start and load in the same IDLE cycle, then a jump past the memory top wraps to word 0.
  task automatic test_start_load_wrap();
    exp_t e;
    logic jmp_seq [3] = '{1'b0, 1'b1, 1'b0};
    exp_t t [4] = '{
      '{32'h0, 32'h0,   32'h0,   1'b0, cnt(0)},
      '{WNEW,  32'd4,   32'd4,   1'b0, cnt(1)},
      '{32'h0, 32'h0,   32'h400, 1'b0, cnt(1)},
      '{WNEW,  32'h404, 32'h404, 1'b0, cnt(2)}
    };
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(t[k]);
      if (k == 0) begin
        i_start = 1;
        load(8'd0, WNEW);
        i_start = 0;
      end else begin
        drive(1, 0, 0, 0, 0, jmp_seq[k-1], 32'h400);
        tick();
      end
      e = exp_q.pop_front();
      n_checks++;
      if (o_instruction !== e.instr || o_pc4 !== e.pc4 || o_pc !== e.pc ||
          o_halted !== e.halted || o_fetch_count !== e.cnt)
        $display("FAIL start_load_wrap[%0d]: got instr=%h pc4=%h pc=%h halted=%b cnt=%0d want instr=%h pc4=%h pc=%h halted=%b cnt=%0d",
                 k, o_instruction, o_pc4, o_pc, o_halted, o_fetch_count, e.instr, e.pc4, e.pc, e.halted, e.cnt);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_stall();
    test_jump();
    test_branch_priority();
    test_load_in_run();
    test_start_load_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Front pipeline stage of the MIPS core: holds the program counter and an instruction memory that the debug unit loads.
- On each enabled step it fetches one word and captures it, with PC+4, into the IF/ID latch that feeds the decode stage.
- It applies branch and jump redirects, hazard stalls and flushes.
- It detects the HALT word and freezes fetch.

## Interface

Parameters:
- NB, 32, datapath and PC width
- IMEM_WORDS, 256, instruction memory depth in 32-bit words
- ADDR_NB, 8, word-address width, log2(IMEM_WORDS)
- HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch

Ports:
- i_clk, in, 1, single clock, all state updates on rising edge
- i_reset, in, 1, synchronous, active-low reset
- i_step, in, 1, pipeline advance enable from debug unit
- i_start, in, 1, leave IDLE and begin fetching
- i_stall, in, 1, hazard unit: hold PC and IF/ID
- i_flush, in, 1, load NOP into IF/ID
- i_branch_taken, in, 1, EX-resolved branch redirect
- i_branch_addr, in, NB, branch target
- i_jump, in, 1, ID-resolved jump redirect
- i_jump_addr, in, NB, jump target
- i_load_en, in, 1, debug program write strobe
- i_load_addr, in, ADDR_NB, word address for program write
- i_load_data, in, NB, program word
- o_instruction, out, NB, IF/ID instruction to decode
- o_pc4, out, NB, IF/ID PC+4 to decode
- o_pc, out, NB, current fetch PC
- o_halted, out, 1, HALT fetched, fetch frozen
- o_fetch_count, out, NB, fetched-instruction counter (see Configuration)

## Operation

- State machine with three states.
  - IDLE: program loading allowed. PC held at 0. IF/ID holds NOP (32'h0). i_start=1 moves to RUN next edge.
  - RUN: an advance occurs on any edge with i_step=1. Loads are ignored.
  - HALTED: o_halted=1, PC frozen. Every advance writes NOP into IF/ID. Only reset exits.
- Instruction memory:
  - Write is synchronous, accepted only in IDLE: i_load_en=1 writes i_load_data to imem[i_load_addr].
  - Read is combinational at imem[PC[ADDR_NB+1:2]]. PC[1:0] are ignored. Upper PC bits wrap modulo IMEM_WORDS.
  - Reset does not clear memory contents.
- Next-PC priority on an advance in RUN, highest first:
  1. i_branch_taken: PC=i_branch_addr. The older instruction wins over a simultaneous jump.
  2. i_jump: PC=i_jump_addr.
  3. i_stall: PC held.
  4. Otherwise: PC=PC+4, modulo 2^NB.
- IF/ID update on an advance in RUN:
  - i_flush, i_branch_taken or i_jump: IF/ID={NOP, 0}, even if i_stall=1.
  - Else i_stall: IF/ID held.
  - Else: IF/ID={fetched word, PC+4}.
- HALT: if the fetched word equals HALT_WORD and it is latched normally (no flush, no stall), then:
  - it enters IF/ID so downstream stages see it;
  - PC is not incremented;
  - state goes to HALTED on the same edge.
- Without i_step, or in IDLE/HALTED with no advance, all state is held.

## Timing

- Reset values when i_reset=0 at an edge: state IDLE, PC=0, o_instruction=0, o_pc4=0, o_halted=0, o_fetch_count=0. This overrides every other input.
- Fetch latency: the word at PC appears on o_instruction one advancing edge later.
- o_pc is the PC register value. o_pc4 is the PC+4 of the instruction currently in IF/ID.
- A redirect is visible on o_pc the edge after it is asserted. The instruction fetched in that cycle is discarded as NOP.
- o_halted rises on the same edge that latches HALT_WORD into IF/ID.
- i_start and i_load_en in the same IDLE cycle: the write completes and the state becomes RUN.

## Configuration

- FETCH_COUNT_EN defined:
  - o_fetch_count increments by 1 on every RUN advance that latches a fetched word (not NOP-by-flush, not stall). The HALT word is included.
  - Wraps at 2^NB.
- FETCH_COUNT_EN undefined: no counter logic; o_fetch_count is constant 0.

## Test plan

- Reset, load words 0..3 with 32'h20010005, 32'h20020003, 32'h00221820, HALT, start, step 4 times:
  - o_instruction sequence is the three words then HALT;
  - o_pc4 is 4, 8, 12, 16;
  - o_halted=1 and o_pc=12.
- i_stall=1 for 2 steps after the first fetch: o_pc stays 4 and o_instruction stays 32'h20010005; the sequence then resumes.
- i_jump=1 with i_jump_addr=32'h20 at PC=4: the next edge gives o_pc=32'h20 and o_instruction=0, then imem[8] is fetched.
- i_branch_taken=1 (addr 32'h40) and i_jump=1 (addr 32'h20) together: o_pc=32'h40.
- In RUN, i_load_en=1 to address 0 with data 32'hDEADBEEF: memory is unchanged. Then i_reset=0 mid-run: all outputs return to 0 and the state is IDLE.
- With FETCH_COUNT_EN, run the first scenario: o_fetch_count=4. Without it, o_fetch_count stays 0.
